// File: rtl/deskew_8bit.sv
// Realigns skewed systolic-array product bits into whole words and buffers them
// in a small FIFO with backpressure and a sticky overflow flag.
module deskew_8bit #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [1:8] d,
  output logic [1:8] q,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [3:0] fifo_cnt,
  output logic       overflow
);

  localparam int AW = $clog2(DEPTH);

  generate
    if (DEPTH != 2 && DEPTH != 4 && DEPTH != 8) begin : g_bad_depth
      $error("deskew_8bit: DEPTH must be 2, 4 or 8");
    end
  endgenerate

  logic [6:0] vpipe;
  logic       aligned_valid;
  logic [1:8] aligned;

  always_ff @(posedge clk) begin
    if (rst) vpipe <= '0;
    else     vpipe <= {vpipe[5:0], in_valid};
  end

  assign aligned_valid = vpipe[6];

  // Bit k arrives k-1 cycles after bit 1, so it needs 8-k delay stages to line up.
  generate
    for (genvar k = 1; k <= 7; k++) begin : g_aln
      logic [7-k:0] sr;
      if (k == 7) begin : g_one
        always_ff @(posedge clk) begin
          if (rst) sr <= '0;
          else     sr <= d[k];
        end
      end else begin : g_chain
        always_ff @(posedge clk) begin
          if (rst) sr <= '0;
          else     sr <= {sr[6-k:0], d[k]};
        end
      end
      assign aligned[k] = sr[7-k];
    end
  endgenerate

  assign aligned[8] = d[8];

  logic [1:8]    mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic          full;
  logic          pop;
  logic          push;

  assign full      = (fifo_cnt == 4'(DEPTH));
  assign out_valid = (fifo_cnt != 4'd0);
  assign pop       = out_valid & out_ready;
  // A pop on the same edge frees the head slot, so a full FIFO can still accept.
  assign push      = aligned_valid & (~full | pop);
  assign q         = out_valid ? mem[rptr] : '0;

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= aligned;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr     <= '0;
      rptr     <= '0;
      fifo_cnt <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 4'd1;
        2'b01:   fifo_cnt <= fifo_cnt - 4'd1;
        default: fifo_cnt <= fifo_cnt;
      endcase
      if (aligned_valid && full && !pop) overflow <= 1'b1;
    end
  end

endmodule
